// File: rtl/wb_cmd_master.sv
// Wishbone classic-cycle initiator: turns a valid/ready command stream into
// single or incrementing-burst bus transfers with one response per beat.
module wb_cmd_master #(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [WB_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                       cmd_we,
  input  logic [WB_DATA_WIDTH/8-1:0] cmd_sel,
  input  logic [3:0]                 cmd_len,
  input  logic                       wdat_valid,
  output logic                       wdat_ready,
  input  logic [WB_DATA_WIDTH-1:0]   wdat,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WB_DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]                 rsp_status,
  output logic                       rsp_last,
  output logic [WB_ADDR_WIDTH-1:0]   wb_adr,
  output logic [WB_DATA_WIDTH-1:0]   wb_dat_w,
  input  logic [WB_DATA_WIDTH-1:0]   wb_dat_r,
  output logic                       wb_cyc,
  output logic                       wb_stb,
  output logic                       wb_we,
  output logic [WB_DATA_WIDTH/8-1:0] wb_sel,
  input  logic                       wb_ack,
  input  logic                       wb_err
);

  localparam int SEL_W = WB_DATA_WIDTH / 8;
  localparam logic [WB_ADDR_WIDTH-1:0] ADDR_STEP = WB_ADDR_WIDTH'(SEL_W);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WDATA = 2'd1;
  localparam logic [1:0] ST_BUS   = 2'd2;
  localparam logic [1:0] ST_RSP   = 2'd3;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_ERR     = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]    state_reg, state_next;
  logic [3:0]    remaining_reg;
  logic [TW-1:0] tcnt_reg;
  logic          timeout_hit;
  logic          cmd_fire;
  logic          wdat_fire;
  logic          bus_term;
  logic [1:0]    beat_status;

  assign cmd_fire  = cmd_valid && cmd_ready;
  assign wdat_fire = wdat_valid && wdat_ready;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      assign timeout_hit = (tcnt_reg == T_LAST);
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  assign bus_term = wb_ack || wb_err || timeout_hit;

  // err beats ack if both arrive together; a real termination beats the timeout
  always_comb begin
    beat_status = STATUS_TIMEOUT;
    if (wb_err) begin
      beat_status = STATUS_ERR;
    end else if (wb_ack) begin
      beat_status = STATUS_OK;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_fire) begin
          state_next = cmd_we ? ST_WDATA : ST_BUS;
        end
      end
      ST_WDATA: begin
        if (wdat_fire) begin
          state_next = ST_BUS;
        end
      end
      ST_BUS: begin
        if (bus_term) begin
          state_next = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_next = rsp_last ? ST_IDLE : (wb_we ? ST_WDATA : ST_BUS);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake and bus strobes are registered from the next state so every
  // output is glitch-free and reads as zero throughout reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      remaining_reg <= '0;
      tcnt_reg      <= '0;
      cmd_ready     <= 1'b0;
      wdat_ready    <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_last      <= 1'b0;
      rsp_data      <= '0;
      rsp_status    <= STATUS_OK;
      wb_cyc        <= 1'b0;
      wb_stb        <= 1'b0;
      wb_we         <= 1'b0;
      wb_adr        <= '0;
      wb_dat_w      <= '0;
      wb_sel        <= '0;
    end else begin
      state_reg  <= state_next;
      cmd_ready  <= (state_next == ST_IDLE);
      wdat_ready <= (state_next == ST_WDATA);
      rsp_valid  <= (state_next == ST_RSP);
      wb_stb     <= (state_next == ST_BUS);
      // cyc holds through WDATA between beats so the fabric grant is kept
      wb_cyc     <= (state_next == ST_BUS) || (state_next == ST_RSP) ||
                    ((state_next == ST_WDATA) && wb_cyc);
      tcnt_reg   <= (state_reg == ST_BUS) ? tcnt_reg + 1'b1 : '0;

      case (state_reg)
        ST_IDLE: begin
          if (cmd_fire) begin
            wb_adr        <= cmd_addr;
            wb_we         <= cmd_we;
            wb_sel        <= cmd_sel;
            remaining_reg <= cmd_len;
          end
        end
        ST_WDATA: begin
          if (wdat_fire) begin
            wb_dat_w <= wdat;
          end
        end
        ST_BUS: begin
          if (bus_term) begin
            rsp_status <= beat_status;
            rsp_data   <= (beat_status == STATUS_OK && !wb_we) ? wb_dat_r : '0;
            rsp_last   <= (remaining_reg == 4'd0) || (beat_status != STATUS_OK);
          end
        end
        ST_RSP: begin
          if (rsp_ready && !rsp_last) begin
            wb_adr        <= wb_adr + ADDR_STEP;
            remaining_reg <= remaining_reg - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: scripted Wishbone slave, one task per scenario.
module tb_wb_cmd_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_sel, cmd_len;
  logic        wdat_valid, wdat_ready;
  logic [31:0] wdat;
  logic        rsp_valid, rsp_ready, rsp_last;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_status;
  logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
  logic [3:0]  wb_sel;

  wb_cmd_master #(
    .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_we(cmd_we), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .rsp_last(rsp_last),
    .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
    .wb_ack(wb_ack), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scripted slave: terminates after slv_wait stalled cycles, err on one chosen beat
  logic [7:0]  slv_wait;
  int          slv_err_beat;
  bit          slv_mute;
  bit          force_ack;
  logic [31:0] slv_data;
  logic [7:0]  stb_cnt;
  int          beat_cnt;
  logic        slv_match;

  always_ff @(posedge clk) begin
    if (rst || !wb_stb || wb_ack || wb_err) stb_cnt <= '0;
    else stb_cnt <= stb_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || !wb_cyc) beat_cnt <= 0;
    else if (wb_stb && (wb_ack || wb_err)) beat_cnt <= beat_cnt + 1;
  end

  assign slv_match = wb_stb && !slv_mute && (stb_cnt == slv_wait);
  assign wb_err    = slv_match && (beat_cnt == slv_err_beat);
  assign wb_ack    = (slv_match && (beat_cnt != slv_err_beat)) || force_ack;
  assign wb_dat_r  = slv_data + 32'(beat_cnt);

  int vec_cnt;
  int err_cnt;

  logic [31:0] wdat_tab [16];
  logic [31:0] beat_adr [$];
  logic [31:0] beat_dat [$];
  logic [3:0]  beat_sel [$];
  logic        beat_we  [$];
  logic [31:0] rsp_dat_q [$];
  logic [1:0]  rsp_st_q [$];
  logic        rsp_last_q [$];
  int          stb_rise_q [$];
  int          rsp_cyc_q [$];
  int          stb_hi;
  int          rsp_first_cyc;
  bit          cyc_gap;
  bit          hold_bad;

  // Issues one command and services wdat/rsp until the last response handshakes.
  // Called and returns at a falling edge; iteration 0 is the command cycle.
  task automatic run_cmd(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                         input logic [3:0] len, input int hold);
    int widx, hold_left, n;
    bit done, started, prev_stb, issued;
    logic [31:0] held_data;
    beat_adr.delete(); beat_dat.delete(); beat_sel.delete(); beat_we.delete();
    rsp_dat_q.delete(); rsp_st_q.delete(); rsp_last_q.delete();
    stb_rise_q.delete(); rsp_cyc_q.delete();
    stb_hi = 0; rsp_first_cyc = -1; cyc_gap = 0; hold_bad = 0;
    widx = 0; hold_left = hold; done = 0; started = 0; prev_stb = 0; issued = 0;
    held_data = '0;
    cmd_valid = 1'b1; cmd_addr = addr; cmd_we = we; cmd_sel = sel; cmd_len = len;
    for (n = 0; n < 300 && !done; n++) begin
      if (issued) cmd_valid = 1'b0;
      if (cmd_valid && cmd_ready) issued = 1;
      if (wb_stb) stb_hi++;
      if (wb_stb && !prev_stb) stb_rise_q.push_back(n);
      prev_stb = wb_stb;
      if (wb_stb && (wb_ack || wb_err)) begin
        beat_adr.push_back(wb_adr); beat_dat.push_back(wb_dat_w);
        beat_sel.push_back(wb_sel); beat_we.push_back(wb_we);
      end
      if (wb_cyc) started = 1;
      else if (started) cyc_gap = 1;
      if (rsp_valid && rsp_first_cyc < 0) rsp_first_cyc = n;
      if (rsp_valid && hold_left > 0) begin
        if (hold_left == hold) held_data = rsp_data;
        else if (rsp_data !== held_data || wb_stb !== 1'b0) hold_bad = 1;
        rsp_ready = 1'b0;
        hold_left--;
      end else begin
        rsp_ready = 1'b1;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_dat_q.push_back(rsp_data); rsp_st_q.push_back(rsp_status);
        rsp_last_q.push_back(rsp_last); rsp_cyc_q.push_back(n);
        $display("  rsp beat %0d: adr=%h data=%h status=%b last=%b cycle=%0d",
                 rsp_dat_q.size() - 1, wb_adr, rsp_data, rsp_status, rsp_last, n);
        if (rsp_last) done = 1;
      end
      wdat_valid = we && (widx <= int'(len));
      wdat = (widx < 16) ? wdat_tab[widx] : 32'h0;
      if (wdat_valid && wdat_ready) widx++;
      @(negedge clk);
    end
    cmd_valid = 1'b0; wdat_valid = 1'b0;
    if (!done) begin
      vec_cnt++; err_cnt++;
      $display("FAIL cmd_completion: no last response within 300 cycles, got %0d responses, required last=1",
               rsp_st_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vec_cnt++; if (cmd_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_cmd_ready: got %b required 0", cmd_ready); end
    vec_cnt++; if ({wb_cyc, wb_stb, wb_we} !== 3'b000) begin err_cnt++; $display("FAIL reset_bus_ctrl: got cyc/stb/we=%b required 000", {wb_cyc, wb_stb, wb_we}); end
    vec_cnt++; if ({rsp_valid, rsp_last, wdat_ready} !== 3'b000) begin err_cnt++; $display("FAIL reset_handshakes: got rsp_valid/rsp_last/wdat_ready=%b required 000", {rsp_valid, rsp_last, wdat_ready}); end
    vec_cnt++; if ({wb_adr, wb_dat_w, rsp_data} !== 96'h0) begin err_cnt++; $display("FAIL reset_datapath: got adr=%h dat_w=%h rsp_data=%h required 0", wb_adr, wb_dat_w, rsp_data); end
    vec_cnt++; if ({wb_sel, rsp_status} !== 6'h0) begin err_cnt++; $display("FAIL reset_sel_status: got sel=%h status=%b required 0", wb_sel, rsp_status); end
    rst = 1'b0;
    @(negedge clk);
    vec_cnt++; if (cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_release_ready: got %b required 1", cmd_ready); end
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    slv_wait = 8'd2; slv_err_beat = -1; slv_data = 32'hDEAD_BEEF;
    run_cmd(32'h1000_0004, 1'b0, 4'hF, 4'd0, 0);
    vec_cnt++; if (stb_hi !== 3) begin err_cnt++; $display("FAIL read_stb_cycles: got %0d required 3", stb_hi); end
    vec_cnt++; if (stb_rise_q.size() !== 1 || stb_rise_q[0] !== 1) begin err_cnt++; $display("FAIL read_stb_latency: got %0d rises required 1 at cycle 1", stb_rise_q.size()); end
    vec_cnt++; if (beat_adr.size() !== 1 || beat_adr[0] !== 32'h1000_0004 || beat_sel[0] !== 4'hF || beat_we[0] !== 1'b0) begin err_cnt++; $display("FAIL read_bus_beat: got %0d beats required adr 10000004 sel f we 0", beat_adr.size()); end
    vec_cnt++; if (rsp_st_q.size() !== 1) begin err_cnt++; $display("FAIL read_rsp_count: got %0d required 1", rsp_st_q.size()); end
    else begin
      vec_cnt++; if (rsp_dat_q[0] !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL read_rsp_data: got %h required deadbeef", rsp_dat_q[0]); end
      vec_cnt++; if (rsp_st_q[0] !== 2'b00 || rsp_last_q[0] !== 1'b1) begin err_cnt++; $display("FAIL read_rsp_status_last: got %b/%b required 00/1", rsp_st_q[0], rsp_last_q[0]); end
      vec_cnt++; if (rsp_cyc_q[0] !== 4) begin err_cnt++; $display("FAIL read_rsp_cycle: got %0d required 4", rsp_cyc_q[0]); end
    end
    vec_cnt++; if (wb_cyc !== 1'b0 || cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL read_end_state: got cyc=%b cmd_ready=%b required 0/1", wb_cyc, cmd_ready); end
    $display("test_single_read done");
  endtask

  task automatic test_burst_write();
    logic [31:0] exp_adr [4];
    logic [31:0] exp_dat [4];
    exp_adr = '{32'h1200_0000, 32'h1200_0004, 32'h1200_0008, 32'h1200_000C};
    exp_dat = '{32'h11, 32'h22, 32'h33, 32'h44};
    wdat_tab[0] = 32'h11; wdat_tab[1] = 32'h22; wdat_tab[2] = 32'h33; wdat_tab[3] = 32'h44;
    slv_wait = 8'd0; slv_err_beat = -1; slv_data = 32'h0BAD_0000;
    run_cmd(32'h1200_0000, 1'b1, 4'hF, 4'd3, 0);
    vec_cnt++; if (beat_adr.size() !== 4) begin err_cnt++; $display("FAIL wr_beat_count: got %0d required 4", beat_adr.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        vec_cnt++;
        if (beat_adr[i] !== exp_adr[i] || beat_dat[i] !== exp_dat[i] || beat_we[i] !== 1'b1) begin
          err_cnt++; $display("FAIL wr_beat%0d: got adr=%h dat=%h we=%b required adr=%h dat=%h we=1", i, beat_adr[i], beat_dat[i], beat_we[i], exp_adr[i], exp_dat[i]);
        end
      end
    end
    vec_cnt++; if (cyc_gap !== 1'b0) begin err_cnt++; $display("FAIL wr_cyc_continuous: got gap=%b required 0", cyc_gap); end
    vec_cnt++; if (stb_rise_q.size() !== 4) begin err_cnt++; $display("FAIL wr_stb_count: got %0d required 4", stb_rise_q.size()); end
    vec_cnt++; if (rsp_st_q.size() !== 4) begin err_cnt++; $display("FAIL wr_rsp_count: got %0d required 4", rsp_st_q.size()); end
    else begin
      vec_cnt++; if ({rsp_last_q[0], rsp_last_q[1], rsp_last_q[2], rsp_last_q[3]} !== 4'b0001) begin err_cnt++; $display("FAIL wr_rsp_last: got %b%b%b%b required 0001", rsp_last_q[0], rsp_last_q[1], rsp_last_q[2], rsp_last_q[3]); end
      vec_cnt++; if (rsp_dat_q[1] !== 32'h0 || rsp_st_q[3] !== 2'b00) begin err_cnt++; $display("FAIL wr_rsp_fields: got data=%h status=%b required 0/00", rsp_dat_q[1], rsp_st_q[3]); end
    end
    $display("test_burst_write done");
  endtask

  task automatic test_error_abort();
    slv_wait = 8'd0; slv_err_beat = 1; slv_data = 32'hA5A5_0000;
    run_cmd(32'h2000_0000, 1'b0, 4'hF, 4'd3, 0);
    vec_cnt++; if (rsp_st_q.size() !== 2) begin err_cnt++; $display("FAIL err_rsp_count: got %0d required 2", rsp_st_q.size()); end
    else begin
      vec_cnt++; if (rsp_st_q[0] !== 2'b00 || rsp_last_q[0] !== 1'b0 || rsp_dat_q[0] !== 32'hA5A5_0000) begin err_cnt++; $display("FAIL err_first_rsp: got %b/%b/%h required 00/0/a5a50000", rsp_st_q[0], rsp_last_q[0], rsp_dat_q[0]); end
      vec_cnt++; if (rsp_st_q[1] !== 2'b01 || rsp_last_q[1] !== 1'b1) begin err_cnt++; $display("FAIL err_second_rsp: got %b/%b required 01/1", rsp_st_q[1], rsp_last_q[1]); end
    end
    vec_cnt++; if (stb_rise_q.size() !== 2) begin err_cnt++; $display("FAIL err_stb_count: got %0d required 2", stb_rise_q.size()); end
    repeat (3) @(negedge clk);
    vec_cnt++; if (wb_stb !== 1'b0 || wb_cyc !== 1'b0 || cmd_ready !== 1'b1) begin err_cnt++; $display("FAIL err_no_third_beat: got stb=%b cyc=%b cmd_ready=%b required 0/0/1", wb_stb, wb_cyc, cmd_ready); end
    $display("test_error_abort done");
  endtask

  task automatic test_timeout();
    slv_wait = 8'd0; slv_err_beat = -1; slv_mute = 1;
    run_cmd(32'h3000_0000, 1'b0, 4'hF, 4'd0, 0);
    slv_mute = 0;
    vec_cnt++; if (stb_hi !== 16) begin err_cnt++; $display("FAIL to_stb_cycles: got %0d required 16", stb_hi); end
    vec_cnt++; if (rsp_first_cyc !== 17) begin err_cnt++; $display("FAIL to_rsp_cycle: got %0d required 17", rsp_first_cyc); end
    vec_cnt++; if (rsp_st_q.size() !== 1) begin err_cnt++; $display("FAIL to_rsp_count: got %0d required 1", rsp_st_q.size()); end
    else begin
      vec_cnt++; if (rsp_st_q[0] !== 2'b10 || rsp_last_q[0] !== 1'b1 || rsp_dat_q[0] !== 32'h0) begin err_cnt++; $display("FAIL to_rsp_fields: got %b/%b/%h required 10/1/0", rsp_st_q[0], rsp_last_q[0], rsp_dat_q[0]); end
    end
    vec_cnt++; if (cmd_ready !== 1'b1 || wb_cyc !== 1'b0) begin err_cnt++; $display("FAIL to_end_state: got cmd_ready=%b cyc=%b required 1/0", cmd_ready, wb_cyc); end
    $display("test_timeout done");
  endtask

  task automatic test_backpressure();
    slv_wait = 8'd0; slv_err_beat = -1; slv_data = 32'h5000_0000;
    run_cmd(32'h4000_0000, 1'b0, 4'hF, 4'd1, 5);
    vec_cnt++; if (hold_bad !== 1'b0) begin err_cnt++; $display("FAIL bp_hold_stable: got unstable=%b required 0", hold_bad); end
    vec_cnt++; if (rsp_first_cyc !== 2) begin err_cnt++; $display("FAIL bp_first_rsp_cycle: got %0d required 2", rsp_first_cyc); end
    vec_cnt++; if (rsp_st_q.size() !== 2 || stb_rise_q.size() !== 2) begin err_cnt++; $display("FAIL bp_counts: got %0d rsp %0d stb required 2/2", rsp_st_q.size(), stb_rise_q.size()); end
    else begin
      vec_cnt++; if (rsp_cyc_q[0] !== 7) begin err_cnt++; $display("FAIL bp_handshake_cycle: got %0d required 7", rsp_cyc_q[0]); end
      vec_cnt++; if (stb_rise_q[1] !== 8) begin err_cnt++; $display("FAIL bp_second_stb_cycle: got %0d required 8", stb_rise_q[1]); end
      vec_cnt++; if (rsp_dat_q[0] !== 32'h5000_0000 || rsp_dat_q[1] !== 32'h5000_0001) begin err_cnt++; $display("FAIL bp_rsp_data: got %h,%h required 50000000,50000001", rsp_dat_q[0], rsp_dat_q[1]); end
      vec_cnt++; if (rsp_last_q[0] !== 1'b0 || rsp_last_q[1] !== 1'b1) begin err_cnt++; $display("FAIL bp_rsp_last: got %b,%b required 0,1", rsp_last_q[0], rsp_last_q[1]); end
      vec_cnt++; if (beat_adr[1] !== 32'h4000_0004) begin err_cnt++; $display("FAIL bp_second_adr: got %h required 40000004", beat_adr[1]); end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_reset_mid_burst();
    bit found;
    found = 0;
    slv_wait = 8'd3; slv_err_beat = -1; slv_data = 32'h7700_0000;
    cmd_valid = 1'b1; cmd_addr = 32'h5000_0000; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_len = 4'd3;
    rsp_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (wb_stb && beat_cnt == 1) found = 1;
      else @(negedge clk);
    end
    vec_cnt++; if (!found) begin err_cnt++; $display("FAIL rst_reach_beat2: got no second stb within 100 cycles, required one"); end
    $display("  reset asserted during beat 2 at adr=%h", wb_adr);
    rst = 1'b1;
    @(negedge clk);
    force_ack = 1'b1;
    vec_cnt++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin err_cnt++; $display("FAIL rst_bus_drop: got cyc=%b stb=%b required 0/0", wb_cyc, wb_stb); end
    vec_cnt++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0 || wb_adr !== 32'h0) begin err_cnt++; $display("FAIL rst_outputs: got rsp_valid=%b cmd_ready=%b adr=%h required 0/0/0", rsp_valid, cmd_ready, wb_adr); end
    rst = 1'b0;
    @(negedge clk);
    vec_cnt++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_recover: got cmd_ready=%b rsp_valid=%b required 1/0", cmd_ready, rsp_valid); end
    @(negedge clk);
    vec_cnt++; if (rsp_valid !== 1'b0 || wb_stb !== 1'b0 || wb_cyc !== 1'b0) begin err_cnt++; $display("FAIL rst_late_ack_ignored: got rsp_valid=%b stb=%b cyc=%b required 0/0/0", rsp_valid, wb_stb, wb_cyc); end
    force_ack = 1'b0;
    $display("test_reset_mid_burst done");
  endtask

  task automatic test_single_write_sel();
    wdat_tab[0] = 32'hCAFE_F00D;
    slv_wait = 8'd1; slv_err_beat = -1; slv_data = 32'h0;
    run_cmd(32'h6000_0010, 1'b1, 4'h3, 4'd0, 0);
    vec_cnt++; if (beat_adr.size() !== 1) begin err_cnt++; $display("FAIL sw_beat_count: got %0d required 1", beat_adr.size()); end
    else begin
      vec_cnt++; if (beat_adr[0] !== 32'h6000_0010 || beat_dat[0] !== 32'hCAFE_F00D || beat_sel[0] !== 4'h3 || beat_we[0] !== 1'b1) begin err_cnt++; $display("FAIL sw_beat: got adr=%h dat=%h sel=%h we=%b required 60000010/cafef00d/3/1", beat_adr[0], beat_dat[0], beat_sel[0], beat_we[0]); end
    end
    vec_cnt++; if (rsp_st_q.size() !== 1 || rsp_st_q[0] !== 2'b00 || rsp_dat_q[0] !== 32'h0 || rsp_last_q[0] !== 1'b1) begin err_cnt++; $display("FAIL sw_rsp: got %0d responses, required one with 00/0/last"
, rsp_st_q.size()); end
    vec_cnt++; if (stb_rise_q.size() !== 1 || stb_rise_q[0] !== 2) begin err_cnt++; $display("FAIL sw_stb_latency: got %0d rises required 1 at cycle 2", stb_rise_q.size()); end
    $display("test_single_write_sel done");
  endtask

  initial begin
    vec_cnt = 0; err_cnt = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_we = 1'b0; cmd_sel = '0; cmd_len = '0;
    wdat_valid = 1'b0; wdat = '0; rsp_ready = 1'b1;
    slv_wait = '0; slv_err_beat = -1; slv_mute = 0; force_ack = 0; slv_data = '0;
    for (int i = 0; i < 16; i++) wdat_tab[i] = '0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_burst_write();
    test_error_abort();
    test_timeout();
    test_backpressure();
    test_reset_mid_burst();
    test_single_write_sel();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Synthesizable Wishbone classic-cycle initiator that turns a valid/ready command stream into single or incrementing-burst bus transfers. It drives the master side of a `wb_if` connection, such as an `m0`/`m1` port of `wb_interconnect_2x2` in front of `wb_rom`/`wb_sram`. A valid/ready response stream returns read data and completion status per beat. The block serves as a DMA/loader front end and as a CPU-free traffic source for fabric bring-up.

## Interface
- WB_ADDR_WIDTH, 32, address width.
- WB_DATA_WIDTH, 32, data width; byte-select width is WB_DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, maximum cycles stb may wait for ack/err; 0 disables the timeout.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when both are high.
- cmd_addr  in  WB_ADDR_WIDTH  first beat address, word aligned.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_sel  in  WB_DATA_WIDTH/8  byte selects, applied to every beat.
- cmd_len  in  4  beats minus 1 (0..15 encodes 1..16 beats).
- wdat_valid / wdat_ready  in / out  1  write-data handshake, one transfer per write beat.
- wdat  in  WB_DATA_WIDTH  write data.
- rsp_valid / rsp_ready  out / in  1  response handshake, one response per beat.
- rsp_data  out  WB_DATA_WIDTH  read data; 0 for writes.
- rsp_status  out  2  00 OK, 01 ERR, 10 TIMEOUT.
- rsp_last  out  1  final response of the command.
- wb_adr / wb_dat_w  out  WB_ADDR_WIDTH / WB_DATA_WIDTH  bus address and write data.
- wb_dat_r  in  WB_DATA_WIDTH  bus read data.
- wb_cyc, wb_stb, wb_we  out  1  bus control.
- wb_sel  out  WB_DATA_WIDTH/8  byte selects.
- wb_ack, wb_err  in  1  slave termination.

## Operation
- States: IDLE, WDATA, BUS, RSP.
- IDLE:
  - cmd_ready = 1.
  - On command handshake, latch addr, we, sel and remaining beats = cmd_len.
  - Go to WDATA if writing, else BUS.
- WDATA:
  - wdat_ready = 1.
  - On handshake, latch wdat into wb_dat_w and go to BUS.
  - wb_cyc stays high from the second beat onward.
- BUS:
  - wb_cyc = wb_stb = 1; wb_adr, wb_we, wb_sel and wb_dat_w are stable.
  - On wb_ack: capture wb_dat_r (reads), set status OK, go to RSP.
  - On wb_err: status ERR, go to RSP. wb_err takes priority if asserted together with wb_ack.
  - Timeout counter clears on BUS entry. When it reaches TIMEOUT_CYCLES with no termination: status TIMEOUT, go to RSP.
- RSP:
  - wb_stb = 0 and rsp_valid = 1.
  - rsp_last = 1 when remaining beats = 0 or status ≠ OK.
  - On rsp handshake:
    - If last: wb_cyc = 0 and go to IDLE.
    - Otherwise: address += WB_DATA_WIDTH/8 (modulo 2^WB_ADDR_WIDTH), remaining decrements, go to WDATA or BUS.
- ERR or TIMEOUT aborts the remaining beats; no further bus cycles are issued for that command.
- wb_ack/wb_err are ignored outside BUS.
- wb_cyc is held for the whole command, so the interconnect grant is retained across the burst.

## Timing
- Reset values: cmd_ready, wdat_ready, rsp_valid, rsp_last, wb_cyc, wb_stb and wb_we are 0; wb_adr, wb_dat_w, wb_sel, rsp_data and rsp_status are 0; state is IDLE.
- cmd_ready rises the first cycle after rst is deasserted.
- rst asserted mid-operation: all outputs take their reset values on the next edge. The pending command and any late ack are discarded; no response is produced.
- Command accepted at edge T (read): wb_stb is high from T+1.
- Ack sampled at edge A: wb_stb is low and rsp_valid is high from A+1.
  - Zero-wait slave: exactly one ack per beat, wb_stb high for one cycle.
- A read beat takes at least 2 cycles, plus rsp backpressure. A write beat adds one WDATA cycle when wdat_valid is already high.
- rsp_ready low: stays in RSP with rsp_* stable; no bus activity.
- Timeout: the response appears at cycle T+1+TIMEOUT_CYCLES, with wb_stb high for exactly TIMEOUT_CYCLES cycles.

## Test plan
- Single read:
  - Stimulus: cmd_addr 0x10000004, len 0, sel 0xF; slave acks 2 cycles after stb with data 0xDEADBEEF.
  - Required: stb high 3 cycles; rsp_data 0xDEADBEEF, status 00, last 1; cyc low after the rsp handshake.
- Burst write:
  - Stimulus: 0x12000000, len 3, wdat 0x11,0x22,0x33,0x44, zero-wait slave.
  - Required: wb_adr 0x12000000, 0x12000004, 0x12000008, 0x1200000C with matching wb_dat_w; cyc continuous; 4 responses, last only on the 4th.
- Error abort:
  - Stimulus: 4-beat read, slave returns err on beat 2.
  - Required: 2 responses, the second with status 01 and last 1; no third stb.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES 16, slave never responds.
  - Required: stb high 16 cycles; response status 10, last 1; cmd_ready high again after the handshake.
- Backpressure:
  - Stimulus: 2-beat read with rsp_ready low for 5 cycles after the first response.
  - Required: rsp_valid and data held; second stb starts only after the handshake.
- Reset mid-burst:
  - Stimulus: rst for 1 cycle while in BUS on beat 2; slave acks afterwards.
  - Required: cyc/stb 0 the next cycle; no rsp_valid; cmd_ready 1 the cycle after reset deasserts.
